// File: rtl/ctrl_spi_tx_if.sv
// rtl/ctrl_spi_tx_if.sv - frame request/status and SPI pins of the control-word SPI transmitter
interface ctrl_spi_tx_if #(
   parameter int FRAME_BITS = 112
);
   logic [FRAME_BITS-1:0] i_Frame;
   logic                  i_Start;
   logic                  o_Busy;
   logic                  o_Done;
   logic                  o_SPI_CS;
   logic                  o_SPI_Clock;
   logic                  o_SPI_Data;

   modport master (
      output i_Frame, i_Start,
      input  o_Busy, o_Done, o_SPI_CS, o_SPI_Clock, o_SPI_Data
   );

   modport slave (
      input  i_Frame, i_Start,
      output o_Busy, o_Done, o_SPI_CS, o_SPI_Clock, o_SPI_Data
   );
endinterface

// File: rtl/ctrl_spi_tx.sv
// rtl/ctrl_spi_tx.sv - mode-0 SPI master sending one frame of control words, word 0 first, MSB first
module ctrl_spi_tx #(
   parameter int WORDS     = 7,
   parameter int WORD_BITS = 16,
   parameter int CLK_DIV   = 4,
   parameter int LEAD      = 4,
   parameter int GAP       = 8
) (
   input  logic         Main_Clock,
   input  logic         Reset,
   ctrl_spi_tx_if.slave bus
);
   localparam int NBITS  = WORDS * WORD_BITS;
   localparam int PH_A   = (CLK_DIV > LEAD) ? CLK_DIV : LEAD;
   localparam int PH_MAX = (PH_A > GAP) ? PH_A : GAP;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int BIT_W  = (NBITS > 1) ? $clog2(NBITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD, S_SCK_HIGH, S_SCK_LOW, S_TRAIL, S_GAP
   } state_t;

   state_t           state;
   logic [PH_W-1:0]  phase_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic [NBITS-1:0] shreg;

   // Word 0 moves to the top so a plain left shift yields word 0 MSB first.
   function automatic logic [NBITS-1:0] word_order(input logic [NBITS-1:0] f);
      logic [NBITS-1:0] r;
      r = '0;
      for (int n = 0; n < WORDS; n++)
         r[(WORDS-1-n)*WORD_BITS +: WORD_BITS] = f[n*WORD_BITS +: WORD_BITS];
      return r;
   endfunction

   always_ff @(posedge Main_Clock) begin
      if (Reset) begin
         state           <= S_IDLE;
         phase_cnt       <= '0;
         bit_cnt         <= '0;
         shreg           <= '0;
         bus.o_SPI_CS    <= 1'b1;
         bus.o_SPI_Clock <= 1'b0;
         bus.o_SPI_Data  <= 1'b0;
         bus.o_Busy      <= 1'b0;
         bus.o_Done      <= 1'b0;
      end else begin
         bus.o_Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.i_Start) begin
                  shreg          <= word_order(bus.i_Frame);
                  bus.o_SPI_Data <= bus.i_Frame[WORD_BITS-1];
                  bus.o_SPI_CS   <= 1'b0;
                  bus.o_Busy     <= 1'b1;
                  bit_cnt        <= BIT_W'(NBITS - 1);
                  phase_cnt      <= PH_W'(LEAD - 1);
                  state          <= S_LEAD;
               end
            end
            S_LEAD: begin
               if (phase_cnt == '0) begin
                  bus.o_SPI_Clock <= 1'b1;
                  phase_cnt       <= PH_W'(CLK_DIV - 1);
                  state           <= S_SCK_HIGH;
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            S_SCK_HIGH: begin
               if (phase_cnt == '0) begin
                  bus.o_SPI_Clock <= 1'b0;
                  phase_cnt       <= PH_W'(CLK_DIV - 1);
                  if (bit_cnt == '0) begin
                     state <= S_TRAIL;
                  end else begin
                     // MOSI changes on the falling SCK edge, a full phase before the next rise.
                     shreg          <= {shreg[NBITS-2:0], 1'b0};
                     bus.o_SPI_Data <= shreg[NBITS-2];
                     bit_cnt        <= bit_cnt - 1'b1;
                     state          <= S_SCK_LOW;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            S_SCK_LOW: begin
               if (phase_cnt == '0) begin
                  bus.o_SPI_Clock <= 1'b1;
                  phase_cnt       <= PH_W'(CLK_DIV - 1);
                  state           <= S_SCK_HIGH;
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            S_TRAIL: begin
               if (phase_cnt == '0) begin
                  bus.o_SPI_CS   <= 1'b1;
                  bus.o_Done     <= 1'b1;
                  bus.o_SPI_Data <= 1'b0;
                  phase_cnt      <= PH_W'(GAP - 1);
                  state          <= S_GAP;
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (phase_cnt == '0) begin
                  bus.o_Busy <= 1'b0;
                  state      <= S_IDLE;
               end else begin
                  phase_cnt <= phase_cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ctrl_spi_tx.sv
// tb/tb_ctrl_spi_tx.sv - scoreboard bench: SPI slave monitor checks words, frame timing and Done
module tb_ctrl_spi_tx;
   localparam int WORDS = 7;
   localparam int WB    = 16;
   localparam int NB    = WORDS * WB;

   logic Main_Clock = 1'b0;
   logic Reset;

   ctrl_spi_tx_if #(.FRAME_BITS(NB)) bus ();

   ctrl_spi_tx #(
      .WORDS(WORDS), .WORD_BITS(WB), .CLK_DIV(4), .LEAD(4), .GAP(8)
   ) dut (
      .Main_Clock (Main_Clock),
      .Reset      (Reset),
      .bus        (bus.slave)
   );

   initial forever #5 Main_Clock = ~Main_Clock;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_words [$];
   int          exp_done  [$];
   int          exp_gap   [$];

   logic [15:0] w2  [WORDS] = '{16'h005A, 16'h0123, 16'h0456, 16'h0789, 16'h0ABC, 16'h0DEF, 16'h0064};
   logic [15:0] w4  [WORDS] = '{16'hA5A5, 16'h5A5A, 16'h8001, 16'h7FFE, 16'h0F0F, 16'hF0F0, 16'hC3C3};
   logic [15:0] w5a [WORDS] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
   logic [15:0] w5b [WORDS] = '{16'hBEEF, 16'hCAFE, 16'h0001, 16'h8000, 16'h1234, 16'hFEDC, 16'h00FF};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge Main_Clock);
      #1;
   endtask

   task automatic issue(input logic [15:0] w [WORDS], input int npush, input bit want_done);
      for (int n = 0; n < WORDS; n++) bus.i_Frame[n*WB +: WB] = w[n];
      for (int n = 0; n < npush; n++) exp_words.push_back(w[n]);
      if (want_done) exp_done.push_back(1);
      bus.i_Start = 1'b1;
      tick();
      bus.i_Start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cyc, output int busy_drops);
      bit seen;
      seen       = 1'b0;
      busy_drops = 0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge Main_Clock);
         if (!bus.o_Busy) busy_drops++;
         if (bus.o_Done) seen = 1'b1;
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   // SPI slave sampling on SCK rise, plus frame-timing and Done scoreboard.
   initial begin
      logic        prev_cs, prev_sck;
      logic [15:0] acc;
      int          nbit, rises, lo_len, hi_len;
      prev_cs = 1'b1; prev_sck = 1'b0; acc = '0;
      nbit = 0; rises = 0; lo_len = 0; hi_len = 0;
      forever begin
         @(negedge Main_Clock);
         if (Reset) begin
            prev_cs = 1'b1; prev_sck = 1'b0;
            nbit = 0; rises = 0; lo_len = 0; hi_len = 0;
         end else begin
            if (!bus.o_SPI_CS && bus.o_SPI_Clock && !prev_sck) begin
               acc = {acc[14:0], bus.o_SPI_Data};
               nbit++;
               rises++;
               if (nbit == WB) begin
                  nbit = 0;
                  if (exp_words.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL unexpected_word actual=%0h required=none", acc);
                  end else begin
                     check("spi_word", 32'(acc), 32'(exp_words.pop_front()));
                  end
               end
            end
            if (bus.o_SPI_CS && !prev_cs) begin
               check("frame_sck_rises", rises, NB);
               check("cs_low_cycles", lo_len, 900);
               rises = 0; lo_len = 0; hi_len = 0;
            end
            if (!bus.o_SPI_CS && prev_cs) begin
               if (exp_gap.size() != 0) check("cs_high_cycles", hi_len, exp_gap.pop_front());
               hi_len = 0; nbit = 0;
            end
            if (bus.o_SPI_CS) hi_len++;
            else              lo_len++;
            if (bus.o_Done) begin
               if (exp_done.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_done actual=1 required=0");
               end else begin
                  void'(exp_done.pop_front());
                  check("done_at_cs_rise", 32'(bus.o_SPI_CS && !prev_cs), 32'd1);
               end
            end
            prev_cs  = bus.o_SPI_CS;
            prev_sck = bus.o_SPI_Clock;
         end
      end
   end

   initial begin
      int drops, n;
      Reset       = 1'b1;
      bus.i_Start = 1'b1;
      bus.i_Frame = '1;

      // Reset dominates a held start request.
      for (int i = 0; i < 3; i++) begin
         @(negedge Main_Clock);
         check("rst_cs",   32'(bus.o_SPI_CS),    32'd1);
         check("rst_sck",  32'(bus.o_SPI_Clock), 32'd0);
         check("rst_mosi", 32'(bus.o_SPI_Data),  32'd0);
         check("rst_busy", 32'(bus.o_Busy),      32'd0);
         check("rst_done", 32'(bus.o_Done),      32'd0);
      end
      tick();
      Reset       = 1'b0;
      bus.i_Start = 1'b0;
      repeat (3) tick();

      // Directed frame; Busy stays up GAP cycles after Done.
      issue(w2, WORDS, 1'b1);
      wait_done("frame1", 2000, drops);
      check("frame1_busy_drops", drops, 0);
      n = 0;
      do begin
         @(negedge Main_Clock);
         n++;
      end while (bus.o_Busy && n < 50);
      check("busy_after_done", n, 8);
      repeat (5) tick();

      // A second start mid-frame is ignored.
      issue(w4, WORDS, 1'b1);
      repeat (99) tick();
      bus.i_Start = 1'b1;
      tick();
      bus.i_Start = 1'b0;
      wait_done("ignore", 2000, drops);
      check("ignore_busy_held", drops, 0);
      repeat (1200) tick();
      check("ignore_idle_cs", 32'(bus.o_SPI_CS), 32'd1);
      check("ignore_idle_busy", 32'(bus.o_Busy), 32'd0);

      // Reset mid-frame aborts without Done, then a new frame runs normally.
      issue(w5a, 2, 1'b0);
      repeat (299) tick();
      Reset = 1'b1;
      tick();
      @(negedge Main_Clock);
      check("abort_cs",   32'(bus.o_SPI_CS),    32'd1);
      check("abort_sck",  32'(bus.o_SPI_Clock), 32'd0);
      check("abort_busy", 32'(bus.o_Busy),      32'd0);
      check("abort_done", 32'(bus.o_Done),      32'd0);
      tick();
      Reset = 1'b0;
      check("abort_words_left", exp_words.size(), 0);
      tick();
      issue(w5b, WORDS, 1'b1);
      wait_done("after_abort", 2000, drops);
      repeat (20) tick();

      // Start held high: back-to-back frames, each latching its own data.
      bus.i_Frame = '1;
      for (int i = 0; i < WORDS; i++) exp_words.push_back(16'hFFFF);
      for (int i = 0; i < WORDS; i++) exp_words.push_back(16'h0000);
      exp_done.push_back(1);
      exp_done.push_back(1);
      bus.i_Start = 1'b1;
      wait_done("b2b_first", 2000, drops);
      bus.i_Frame = '0;
      exp_gap.push_back(9);
      wait_done("b2b_second", 2000, drops);
      bus.i_Start = 1'b0;
      repeat (50) tick();

      check("words_left", exp_words.size(), 0);
      check("done_left",  exp_done.size(),  0);
      check("gap_left",   exp_gap.size(),   0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
